// File: rtl/music_rom_sequencer.sv
// -----------------------------------------------------------------------------
// music_rom_sequencer
// Playback controller for the music note ROM. Walks ROM addresses, absorbs the
// one-cycle registered read, decodes {note[11:6], dur[5:0]} words and holds
// each note for eff_dur * TICK_DIV cycles before fetching the next word.
// Note 63 is the end marker; stepping past the last address also ends the song.
//
// Optional build macro: MUSIC_SEQ_PAUSE_EN adds a level-sensitive pause_i that
// freezes the note timers while in PLAY and drops note_valid_o meanwhile.
// -----------------------------------------------------------------------------
module music_rom_sequencer #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 12,
    parameter int TICK_DIV   = 50000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  stop_i,
    input  logic                  loop_i,
    input  logic [ADDR_WIDTH-1:0] start_addr_i,
    output logic [ADDR_WIDTH-1:0] rom_addr_o,
    input  logic [DATA_WIDTH-1:0] rom_data_i,
`ifdef MUSIC_SEQ_PAUSE_EN
    input  logic                  pause_i,
`endif
    output logic [5:0]            note_o,
    output logic                  note_valid_o,
    output logic                  playing_o,
    output logic                  done_o
);

    localparam int                    TICK_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [ADDR_WIDTH-1:0] ADDR_LAST = '1;
    localparam logic [5:0]            END_MARK  = 6'd63;

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_LATCH,
        S_PLAY
    } state_t;

    state_t                  r_state;
    logic [ADDR_WIDTH-1:0]   r_start_addr;
    logic [ADDR_WIDTH-1:0]   r_rom_addr;
    logic [5:0]              r_note;
    logic                    r_note_valid;
    logic                    r_playing;
    logic                    r_done;
    logic [TICK_W-1:0]       r_tick_cnt;
    logic [5:0]              r_dur_cnt;
    logic [5:0]              r_eff_dur;
    // Set when the last address has been played: the next LATCH is an end marker.
    logic                    r_wrap;

    logic [5:0]              w_rom_note;
    logic [5:0]              w_rom_dur;
    logic                    w_tick;
    logic                    w_note_end;
    logic                    w_run;

    assign w_rom_note = rom_data_i[11:6];
    assign w_rom_dur  = rom_data_i[5:0];
    assign w_tick     = (r_tick_cnt == TICK_LAST);
    assign w_note_end = w_tick && (r_dur_cnt == (r_eff_dur - 6'd1));

`ifdef MUSIC_SEQ_PAUSE_EN
    assign w_run = ~pause_i;
`else
    assign w_run = 1'b1;
`endif

    // Sequencer FSM: control priority is rst > stop > start > normal stepping.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it only lives inside the clocked branch;
        // every register, including the latched start address, is cleared here.
        if (rst) begin
            r_state      <= S_IDLE;
            r_start_addr <= '0;
            r_rom_addr   <= '0;
            r_note       <= '0;
            r_note_valid <= 1'b0;
            r_playing    <= 1'b0;
            r_done       <= 1'b0;
            r_tick_cnt   <= '0;
            r_dur_cnt    <= '0;
            r_eff_dur    <= '0;
            r_wrap       <= 1'b0;
        end else begin
            // done_o is a one-cycle pulse: cleared every cycle unless re-raised below.
            r_done <= 1'b0;

            if (stop_i) begin
                // Stop beats a simultaneous start and never signals done.
                r_state      <= S_IDLE;
                r_note       <= '0;
                r_note_valid <= 1'b0;
                r_playing    <= 1'b0;
                r_wrap       <= 1'b0;
            end else if (start_i) begin
                // Start (or restart) from a freshly latched address.
                r_start_addr <= start_addr_i;
                r_rom_addr   <= start_addr_i;
                r_state      <= S_FETCH;
                r_playing    <= 1'b1;
                r_wrap       <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_state <= S_IDLE;
                    end

                    S_FETCH: begin
                        // ROM is registering the word at r_rom_addr this cycle.
                        r_state <= S_LATCH;
                    end

                    S_LATCH: begin
                        if (r_wrap || (w_rom_note == END_MARK)) begin
                            r_wrap <= 1'b0;
                            if (loop_i) begin
                                r_rom_addr <= r_start_addr;
                                r_state    <= S_FETCH;
                            end else begin
                                r_done       <= 1'b1;
                                r_note       <= '0;
                                r_note_valid <= 1'b0;
                                r_playing    <= 1'b0;
                                r_state      <= S_IDLE;
                            end
                        end else begin
                            r_note       <= w_rom_note;
                            r_note_valid <= 1'b1;
                            r_tick_cnt   <= '0;
                            r_dur_cnt    <= '0;
                            r_eff_dur    <= (w_rom_dur == 6'd0) ? 6'd1 : w_rom_dur;
                            r_state      <= S_PLAY;
                        end
                    end

                    S_PLAY: begin
                        // Paused cycles neither count nor report a valid note.
                        r_note_valid <= w_run;
                        if (w_run) begin
                            if (w_tick) begin
                                r_tick_cnt <= '0;
                                if (w_note_end) begin
                                    // The last address never wraps; it ends the song instead.
                                    if (r_rom_addr == ADDR_LAST) begin
                                        r_wrap <= 1'b1;
                                    end else begin
                                        r_rom_addr <= r_rom_addr + 1'b1;
                                    end
                                    r_state <= S_FETCH;
                                end else begin
                                    r_dur_cnt <= r_dur_cnt + 6'd1;
                                end
                            end else begin
                                r_tick_cnt <= r_tick_cnt + 1'b1;
                            end
                        end
                    end

                    default: begin
                        r_state <= S_IDLE;
                    end
                endcase
            end
        end
    end

    assign rom_addr_o   = r_rom_addr;
    assign note_o       = r_note;
    assign note_valid_o = r_note_valid;
    assign playing_o    = r_playing;
    assign done_o       = r_done;

endmodule

// File: tb/tb_music_rom_sequencer.sv
// -----------------------------------------------------------------------------
// tb_music_rom_sequencer
// Directed test-plan scenarios plus randomized songs. The reference model
// expands a song into a per-cycle timeline: 2 gap cycles per word, then
// eff_dur * TICK_DIV note cycles, with end-marker / loop / stop handling.
// Build with MUSIC_SEQ_PAUSE_EN to also exercise pause_i.
// -----------------------------------------------------------------------------
module tb_music_rom_sequencer;

    localparam int AW = 10;
    localparam int DW = 12;
    localparam int TD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_i;
    logic          stop_i;
    logic          loop_i;
    logic [AW-1:0] start_addr_i;
    logic [AW-1:0] rom_addr_o;
    logic [DW-1:0] rom_data_i;
    logic [5:0]    note_o;
    logic          note_valid_o;
    logic          playing_o;
    logic          done_o;
`ifdef MUSIC_SEQ_PAUSE_EN
    logic          pause_i = 1'b0;
`endif

    music_rom_sequencer #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .TICK_DIV   (TD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .stop_i       (stop_i),
        .loop_i       (loop_i),
        .start_addr_i (start_addr_i),
        .rom_addr_o   (rom_addr_o),
        .rom_data_i   (rom_data_i),
`ifdef MUSIC_SEQ_PAUSE_EN
        .pause_i      (pause_i),
`endif
        .note_o       (note_o),
        .note_valid_o (note_valid_o),
        .playing_o    (playing_o),
        .done_o       (done_o)
    );

    always #5 clk = ~clk;

    // Behavioural ROM with a one-cycle registered read.
    logic [DW-1:0] rom [0:1023];
    always @(posedge clk) rom_data_i <= rom[rom_addr_o];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [5:0]    note;
        logic          valid;
        logic          playing;
        logic          done;
        logic [AW-1:0] addr;
    } rec_t;

    rec_t exp_q[$];
    int   m_stop;
    int   obs_done_cnt;
    int   obs_done_at;
    int   obs_valid_cnt;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Expand a song starting at sa into the expected output after each edge.
    task automatic build(input int sa, input bit lp, input int max_len, input int stop_k);
        int         a;
        bit         wrapped;
        logic [5:0] cn;
        logic       cv;
        logic [11:0] w;
        int         n;
        int         d;
        int         eff;
        int         cut;
        a       = sa;
        wrapped = 1'b0;
        cn      = 6'd0;
        cv      = 1'b0;
        m_stop  = -1;
        exp_q.delete();
        while (exp_q.size() < max_len) begin
            exp_q.push_back(rec_t'{cn, cv, 1'b1, 1'b0, AW'(a)});
            exp_q.push_back(rec_t'{cn, cv, 1'b1, 1'b0, AW'(a)});
            w = rom[a];
            n = int'(w[11:6]);
            d = int'(w[5:0]);
            if (wrapped || n == 63) begin
                if (lp) begin
                    a       = sa;
                    wrapped = 1'b0;
                end else begin
                    exp_q.push_back(rec_t'{6'd0, 1'b0, 1'b0, 1'b1, AW'(a)});
                    break;
                end
            end else begin
                eff = (d == 0) ? 1 : d;
                cn  = 6'(n);
                cv  = 1'b1;
                for (int i = 0; i < eff * TD; i++)
                    exp_q.push_back(rec_t'{cn, 1'b1, 1'b1, 1'b0, AW'(a)});
                if (a == 1023) wrapped = 1'b1;
                else a++;
            end
        end
        if (!(exp_q[exp_q.size()-1].done && stop_k >= exp_q.size())) begin
            cut = (stop_k < max_len) ? stop_k : max_len;
            while (exp_q.size() > cut) void'(exp_q.pop_back());
            exp_q.push_back(rec_t'{6'd0, 1'b0, 1'b0, 1'b0, exp_q[cut-1].addr});
            m_stop = cut;
        end
    endtask

    // Play one song from IDLE and compare every cycle against the model.
    task automatic run_episode(input int sa, input bit lp, input int max_len, input int stop_k,
                               input bit start_with_stop, input string tag);
        rec_t r;
        build(sa, lp, max_len, stop_k);
        obs_done_cnt  = 0;
        obs_done_at   = -1;
        obs_valid_cnt = 0;
        start_addr_i  = AW'(sa);
        loop_i        = lp;
        start_i       = 1'b1;
        for (int k = 0; k < exp_q.size(); k++) begin
            if (k > 0) begin
                stop_i  = (k == m_stop);
                start_i = (k == m_stop) && start_with_stop;
            end
            step();
            start_i = 1'b0;
            stop_i  = 1'b0;
            r = exp_q[k];
            check({tag, "_note"},    32'(note_o),       32'(r.note));
            check({tag, "_valid"},   32'(note_valid_o), 32'(r.valid));
            check({tag, "_playing"}, 32'(playing_o),    32'(r.playing));
            check({tag, "_done"},    32'(done_o),       32'(r.done));
            check({tag, "_addr"},    32'(rom_addr_o),   32'(r.addr));
            if (done_o) begin
                obs_done_cnt++;
                if (obs_done_at < 0) obs_done_at = k;
            end
            if (note_valid_o) obs_valid_cnt++;
        end
        r = exp_q[exp_q.size()-1];
        for (int k = 0; k < 2; k++) begin
            step();
            check({tag, "_idle_note"},    32'(note_o),       32'd0);
            check({tag, "_idle_valid"},   32'(note_valid_o), 32'd0);
            check({tag, "_idle_playing"}, 32'(playing_o),    32'd0);
            check({tag, "_idle_done"},    32'(done_o),       32'd0);
            check({tag, "_idle_addr"},    32'(rom_addr_o),   32'(r.addr));
        end
        loop_i = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int          sa;
        bit          lp;
        int          stop_k;
        logic [11:0] w;

        for (int i = 0; i < 1024; i++) rom[i] = 12'hFC0;
        rst          = 1'b1;
        start_i      = 1'b0;
        stop_i       = 1'b0;
        loop_i       = 1'b0;
        start_addr_i = '0;
        step();
        step();

        // Reset state.
        check("rst_note",    32'(note_o),       32'd0);
        check("rst_valid",   32'(note_valid_o), 32'd0);
        check("rst_playing", 32'(playing_o),    32'd0);
        check("rst_done",    32'(done_o),       32'd0);
        check("rst_addr",    32'(rom_addr_o),   32'd0);
        rst = 1'b0;
        step();

        // Note 5 dur 2 then end marker, no loop.
        rom[0] = 12'h142;
        rom[1] = 12'hFC0;
        run_episode(0, 1'b0, 60, 1000, 1'b0, "t1");
        check("t1_done_at",  32'(obs_done_at),   32'd12);
        check("t1_done_cnt", 32'(obs_done_cnt),  32'd1);
        check("t1_valid",    32'(obs_valid_cnt), 32'd10);

        // Same song looping: never done, valid from cycle 2 onwards.
        run_episode(0, 1'b1, 40, 1000, 1'b0, "t2");
        check("t2_done_cnt", 32'(obs_done_cnt),  32'd0);
        check("t2_valid",    32'(obs_valid_cnt), 32'd38);

        // dur 0 behaves as dur 1.
        rom[0] = 12'h0C0;
        run_episode(0, 1'b0, 60, 1000, 1'b0, "t3");
        check("t3_done_at", 32'(obs_done_at),   32'd8);
        check("t3_valid",   32'(obs_valid_cnt), 32'd6);

        // Stop and start together mid-note.
        rom[0] = 12'h142;
        run_episode(0, 1'b0, 60, 5, 1'b1, "t4");
        check("t4_done_cnt", 32'(obs_done_cnt), 32'd0);
        check("t4_playing",  32'(playing_o),    32'd0);

        // Last address: plays, then ends without wrapping to 0.
        rom[1023] = 12'h041;
        run_episode(1023, 1'b0, 60, 1000, 1'b0, "t5");
        check("t5_done_at",  32'(obs_done_at),  32'd8);
        check("t5_done_cnt", 32'(obs_done_cnt), 32'd1);
        check("t5_addr",     32'(rom_addr_o),   32'd1023);

        // Restart while playing: new address fetched, new song plays.
        rom[5] = 12'h2C1;
        rom[6] = 12'hFC0;
        start_addr_i = '0;
        start_i      = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        check("rs_note_before", 32'(note_o), 32'd5);
        start_addr_i = AW'(5);
        start_i      = 1'b1;
        step();
        start_i = 1'b0;
        check("rs_addr",    32'(rom_addr_o), 32'd5);
        check("rs_playing", 32'(playing_o),  32'd1);
        step();
        step();
        check("rs_note_new", 32'(note_o), 32'd11);
        repeat (5) step();
        check("rs_done_early", 32'(done_o),     32'd0);
        check("rs_addr_next",  32'(rom_addr_o), 32'd6);
        step();
        check("rs_done", 32'(done_o), 32'd1);
        step();

        // Reset in the middle of a note.
        start_addr_i = '0;
        start_i      = 1'b1;
        step();
        start_i = 1'b0;
        repeat (4) step();
        check("mr_note_before", 32'(note_o), 32'd5);
        rst = 1'b1;
        step();
        check("mr_note",    32'(note_o),       32'd0);
        check("mr_valid",   32'(note_valid_o), 32'd0);
        check("mr_playing", 32'(playing_o),    32'd0);
        check("mr_addr",    32'(rom_addr_o),   32'd0);
        rst = 1'b0;
        step();
        check("mr_idle", 32'(playing_o), 32'd0);

`ifdef MUSIC_SEQ_PAUSE_EN
        // Pause for 10 PLAY cycles of a dur-2 note.
        rom[0] = 12'h142;
        rom[1] = 12'hFC0;
        start_addr_i = '0;
        loop_i       = 1'b0;
        start_i      = 1'b1;
        for (int k = 0; k <= 24; k++) begin
            if (k > 0) start_i = 1'b0;
            pause_i = (k >= 4 && k <= 13);
            step();
            if (k == 3)  check("pz_valid_pre",   32'(note_valid_o), 32'd1);
            if (k == 4)  check("pz_valid_in",    32'(note_valid_o), 32'd0);
            if (k == 13) check("pz_valid_last",  32'(note_valid_o), 32'd0);
            if (k == 13) check("pz_note_hold",   32'(note_o),       32'd5);
            if (k == 14) check("pz_valid_post",  32'(note_valid_o), 32'd1);
            if (k == 19) check("pz_addr_play",   32'(rom_addr_o),   32'd0);
            if (k == 20) check("pz_addr_next",   32'(rom_addr_o),   32'd1);
            if (k == 21) check("pz_done_early",  32'(done_o),       32'd0);
            if (k == 22) check("pz_done",        32'(done_o),       32'd1);
        end
        pause_i = 1'b0;
`endif

        // Randomized songs against the timeline model.
        for (int e = 0; e < 30; e++) begin
            sa = ($urandom_range(0, 3) == 0) ? 1016 + int'($urandom_range(0, 7))
                                             : int'($urandom_range(0, 1023));
            for (int i = 0; i < 16; i++) begin
                w[11:6] = ($urandom_range(0, 4) == 0) ? 6'd63 : 6'($urandom_range(0, 62));
                w[5:0]  = 6'($urandom_range(0, 3));
                rom[(sa + i) % 1024] = w;
            end
            lp     = ($urandom_range(0, 2) == 0);
            stop_k = int'($urandom_range(1, 90));
            run_episode(sa, lp, 70, stop_k, 1'($urandom_range(0, 1)), "rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
